// File: rtl/matvec_mac.sv
// Purpose : signed fixed-point y[j] = sat(round(init[j] + sum_i x[i]*W[i][j])) over external operand stores.
// Latency : 1 + N*M + READ_LAT cycles from accepted start to IDLE (BIAS init adds M + READ_LAT); results read combinationally.
// Backpr. : none; start is accepted only while ready=1, ignored (not queued) while busy; stores must answer in READ_LAT cycles.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start, init_mode        begin op; init_mode 00 CLEAR, 01 KEEP, 10 BIAS, 11 as CLEAR
//   vec_in, mat_in, bias_in operands returned by the external stores for sel_vec/sel_row/sel_col
//   rd_sel                  accumulator index presented on data_out/sat while idle
//   ready, busy, done       idle flag, its complement, one-cycle pulse on return to IDLE
//   sat, data_out           clip flag and rounded/saturated acc[rd_sel]
//   sel_vec, sel_row        input / weight-row index i
//   sel_col                 weight column / bias index j
module matvec_mac #(
    parameter int DATA_W    = 16,
    parameter int FRAC_BITS = 8,
    parameter int IN_BITS   = 2,
    parameter int OUT_BITS  = 4,
    parameter int READ_LAT  = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [1:0]          init_mode,
    input  logic [DATA_W-1:0]   vec_in,
    input  logic [DATA_W-1:0]   mat_in,
    input  logic [DATA_W-1:0]   bias_in,
    input  logic [OUT_BITS-1:0] rd_sel,
    output logic                ready,
    output logic                busy,
    output logic                done,
    output logic                sat,
    output logic [DATA_W-1:0]   data_out,
    output logic [IN_BITS-1:0]  sel_vec,
    output logic [IN_BITS-1:0]  sel_row,
    output logic [OUT_BITS-1:0] sel_col
);

    localparam int N     = 1 << IN_BITS;
    localparam int M     = 1 << OUT_BITS;
    localparam int ACC_W = 2 * DATA_W + IN_BITS + 1;
    localparam int CNT_W = $clog2(M + READ_LAT + 1) + 1;

    localparam logic [1:0] MODE_CLEAR = 2'b00;
    localparam logic [1:0] MODE_BIAS  = 2'b10;

    localparam logic [OUT_BITS-1:0] COL_LAST = OUT_BITS'(M - 1);
    localparam logic [IN_BITS-1:0]  ROW_LAST = IN_BITS'(N - 1);

    // BIAS init: issue columns while cnt < M, wait READ_LAT beats, then one
    // turnaround cycle with sel_col parked at 0 so RUN starts at (0,0).
    localparam logic [CNT_W-1:0] BIAS_SWEEP_END = CNT_W'(M);
    localparam logic [CNT_W-1:0] BIAS_INIT_END  = CNT_W'(M + READ_LAT);
    localparam logic [CNT_W-1:0] DRAIN_END      = CNT_W'((READ_LAT > 0) ? READ_LAT - 1 : 0);

    localparam logic signed [ACC_W:0] RND   = ((ACC_W+1)'(1) << FRAC_BITS) >> 1;
    localparam logic signed [ACC_W:0] MAX_V = (ACC_W+1)'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W:0] MIN_V = (ACC_W+1)'(-(1 << (DATA_W - 1)));

    typedef enum logic [1:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           mode_q, mode_d;
    logic [IN_BITS-1:0]   row_q, row_d;
    logic [OUT_BITS-1:0]  col_q, col_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 done_q, done_d;

    // Beat issued this cycle for the address currently on sel_*.
    logic                 iss_vld;
    logic                 iss_bias;
    logic                 clr_all;

    // Same beat, READ_LAT cycles later, aligned with the returned operands.
    logic                 ret_vld;
    logic                 ret_bias;
    logic [OUT_BITS-1:0]  ret_col;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mode_q  <= MODE_CLEAR;
            row_q   <= '0;
            col_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            row_q   <= row_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        row_d    = row_q;
        col_d    = col_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        iss_vld  = 1'b0;
        iss_bias = 1'b0;
        clr_all  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_INIT;
                    mode_d  = (init_mode == 2'b11) ? MODE_CLEAR : init_mode;
                    row_d   = '0;
                    col_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_INIT: begin
                if (mode_q == MODE_BIAS) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q < BIAS_SWEEP_END) begin
                        iss_vld  = 1'b1;
                        iss_bias = 1'b1;
                        // Wraps to 0 after column M-1, ready for RUN.
                        col_d    = col_q + OUT_BITS'(1);
                    end
                    if (cnt_q == BIAS_INIT_END) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                    end
                end else begin
                    clr_all = (mode_q == MODE_CLEAR);
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                iss_vld = 1'b1;
                if (col_q == COL_LAST && row_q == ROW_LAST) begin
                    // Indices hold at (N-1, M-1) until the next op.
                    cnt_d = '0;
                    if (READ_LAT == 0) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else begin
                    col_d = col_q + OUT_BITS'(1);
                    if (col_q == COL_LAST) begin
                        row_d = row_q + IN_BITS'(1);
                    end
                end
            end
            S_DRAIN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == DRAIN_END) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    generate
        if (READ_LAT == 0) begin : g_comb
            assign ret_vld  = iss_vld;
            assign ret_bias = iss_bias;
            assign ret_col  = col_q;
        end else begin : g_pipe
            logic [READ_LAT-1:0] vld_q;
            logic [READ_LAT-1:0] bias_q;
            logic [OUT_BITS-1:0] col_pipe_q [READ_LAT];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q  <= '0;
                    bias_q <= '0;
                    for (int k = 0; k < READ_LAT; k++) begin
                        col_pipe_q[k] <= '0;
                    end
                end else begin
                    vld_q[0]      <= iss_vld;
                    bias_q[0]     <= iss_bias;
                    col_pipe_q[0] <= col_q;
                    for (int k = 1; k < READ_LAT; k++) begin
                        vld_q[k]      <= vld_q[k-1];
                        bias_q[k]     <= bias_q[k-1];
                        col_pipe_q[k] <= col_pipe_q[k-1];
                    end
                end
            end

            assign ret_vld  = vld_q[READ_LAT-1];
            assign ret_bias = bias_q[READ_LAT-1];
            assign ret_col  = col_pipe_q[READ_LAT-1];
        end
    endgenerate

    logic signed [ACC_W-1:0]    acc_q [M];
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    bias_ext;

    always_comb begin
        prod     = $signed(vec_in) * $signed(mat_in);
        prod_ext = ACC_W'(prod);
        // Bias is in the operand format; align it to the product's 2*FRAC_BITS scale.
        bias_ext = ACC_W'($signed(bias_in)) <<< FRAC_BITS;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < M; k++) begin
                acc_q[k] <= '0;
            end
        end else if (clr_all) begin
            for (int k = 0; k < M; k++) begin
                acc_q[k] <= '0;
            end
        end else if (ret_vld) begin
            if (ret_bias) begin
                acc_q[ret_col] <= bias_ext;
            end else begin
                acc_q[ret_col] <= acc_q[ret_col] + prod_ext;
            end
        end
    end

    // One extra bit so adding the rounding term cannot wrap a KEEP-chained value.
    logic signed [ACC_W:0] acc_sel;
    logic signed [ACC_W:0] rounded;

    always_comb begin
        acc_sel  = (ACC_W+1)'(acc_q[rd_sel]);
        rounded  = (acc_sel + RND) >>> FRAC_BITS;
        sat      = 1'b0;
        data_out = rounded[DATA_W-1:0];
        if (rounded > MAX_V) begin
            sat      = 1'b1;
            data_out = MAX_V[DATA_W-1:0];
        end else if (rounded < MIN_V) begin
            sat      = 1'b1;
            data_out = MIN_V[DATA_W-1:0];
        end
    end

    assign ready   = (state_q == S_IDLE);
    assign busy    = ~ready;
    assign done    = done_q;
    assign sel_vec = row_q;
    assign sel_row = row_q;
    assign sel_col = col_q;

endmodule
